// File: rtl/eq_pkg.sv
// Shared LMS equalizer constants and delay-line address helper.
package eq_pkg;

  localparam int LMS_SAMPLE_W = 16;
  localparam int LMS_TAPS     = 64;
  localparam int DLR_MAX_AW   = 16;

  // Physical slot of a sample 'delay' steps behind the newest one; mask = DEPTH-1.
  function automatic logic [DLR_MAX_AW-1:0] dlr_addr(
    input logic [DLR_MAX_AW-1:0] wr_ptr,
    input logic [DLR_MAX_AW-1:0] delay,
    input logic [DLR_MAX_AW-1:0] mask
  );
    return (wr_ptr - DLR_MAX_AW'(1) - delay) & mask;
  endfunction

endpackage

// File: rtl/dlr_read_port.sv
// One delay-addressed read port: address generation, history bound check and output stage.
// DLR_OUT_REG_EN adds a second output register (latency 2).
module dlr_read_port
  import eq_pkg::*;
#(
  parameter int WIDTH = LMS_SAMPLE_W,
  parameter int DEPTH = LMS_TAPS,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    delay,
  input  logic [AW-1:0]    wr_ptr,
  input  logic [AW:0]      fill,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] ram_q,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             oob
);

  localparam logic [DLR_MAX_AW-1:0] MASK = DLR_MAX_AW'(DEPTH - 1);

  logic             oob_p0;
  logic             vld_p1;
  logic             oob_p1;
  logic [WIDTH-1:0] dout_p1;

  // Stage 0: request cycle, address and bound check from pre-write state
  assign rd_addr = AW'(dlr_addr(DLR_MAX_AW'(wr_ptr), DLR_MAX_AW'(delay), MASK));
  assign oob_p0  = ({1'b0, delay} >= fill);

  // Stage 1: RAM data arrives; oob flag is held with the data so a masked zero persists
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      oob_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) oob_p1 <= oob_p0;
    end
  end

  assign dout_p1 = oob_p1 ? '0 : ram_q;

`ifdef DLR_OUT_REG_EN
  logic             vld_p2;
  logic             oob_p2;
  logic [WIDTH-1:0] dout_p2;

  // Stage 2: extra output register to decouple BRAM clock-to-out
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      oob_p2  <= 1'b0;
      dout_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      oob_p2  <= vld_p1 & oob_p1;
      dout_p2 <= dout_p1;
    end
  end

  assign dout  = dout_p2;
  assign valid = vld_p2;
  assign oob   = oob_p2;
`else
  assign dout  = dout_p1;
  assign valid = vld_p1;
  assign oob   = vld_p1 & oob_p1;
`endif

endmodule

// File: rtl/delay_line_ram.sv
// Circular sample buffer on inferred dual-read block RAM, read by delay (0 = newest).
// Optional macro DLR_OUT_REG_EN: extra output register on both read ports (latency 2).
module delay_line_ram
  import eq_pkg::*;
#(
  parameter int WIDTH = LMS_SAMPLE_W,
  parameter int DEPTH = LMS_TAPS,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    delay_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    delay_b,
  output logic [WIDTH-1:0] dout_a,
  output logic [WIDTH-1:0] dout_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic             oob_a,
  output logic             oob_b,
  output logic [AW:0]      fill,
  output logic             full
);

  localparam logic [AW:0] FILL_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      fill_q;
  logic [AW-1:0]    addr_a;
  logic [AW-1:0]    addr_b;
  logic [WIDTH-1:0] q_a_p1;
  logic [WIDTH-1:0] q_b_p1;
  logic             wr_en;

  function automatic logic [AW:0] sat_fill(input logic [AW:0] f);
    return (f == FILL_MAX) ? f : f + (AW + 1)'(1);
  endfunction

  // flush wins over a same-cycle write; the sample is dropped
  assign wr_en = in_valid & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      fill_q <= '0;
    end else if (in_valid) begin
      wr_ptr <= wr_ptr + AW'(1);
      fill_q <= sat_fill(fill_q);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr] <= in_data;
  end

  // Stage boundary p0 -> p1: read-first synchronous reads, held when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      q_a_p1 <= '0;
      q_b_p1 <= '0;
    end else begin
      if (rd_en_a) q_a_p1 <= ram[addr_a];
      if (rd_en_b) q_b_p1 <= ram[addr_b];
    end
  end

  dlr_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en_a),
    .delay   (delay_a),
    .wr_ptr  (wr_ptr),
    .fill    (fill_q),
    .rd_addr (addr_a),
    .ram_q   (q_a_p1),
    .dout    (dout_a),
    .valid   (valid_a),
    .oob     (oob_a)
  );

  dlr_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en_b),
    .delay   (delay_b),
    .wr_ptr  (wr_ptr),
    .fill    (fill_q),
    .rd_addr (addr_b),
    .ram_q   (q_b_p1),
    .dout    (dout_b),
    .valid   (valid_b),
    .oob     (oob_b)
  );

  assign fill = fill_q;
  assign full = (fill_q == FILL_MAX);

endmodule
